// File: rtl/display_mux_7seg_if.sv
// Display-mux bus: digit data/load/enable/error flags in, segments/anodes/frame pulse out.
// master = controller driving the display; slave = display_mux_7seg.
interface display_mux_7seg_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] datos;
    logic                  carga;
    logic                  habilita;
    logic [N_DIGITS-1:0]   error_dig;
    logic [6:0]            seg;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_done;

    modport master (
        output datos, carga, habilita, error_dig,
        input  seg, an, frame_done
    );

    modport slave (
        input  datos, carga, habilita, error_dig,
        output seg, an, frame_done
    );
endinterface

// File: rtl/display_mux_7seg.sv
// Multiplexed active-low 7-segment hex driver; optional error-digit blink via DISPLAY_MUX_7SEG_BLINK_EN.
// Latency: seg/an registered one clock after idx; new data shows from digit 0 of the next frame.
// No backpressure: carga always captured; habilita=0 freezes the scan and blanks outputs.
module display_mux_7seg #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input logic                  clk,
    input logic                  rst,
    display_mux_7seg_if.slave    bus
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    logic [PW-1:0]              r_presc;
    logic [IW-1:0]              r_idx;
    logic [N_DIGITS-1:0][3:0]   r_pend;
    logic [N_DIGITS-1:0][3:0]   r_disp;
    logic [6:0]                 r_seg;
    logic [N_DIGITS-1:0]        r_an;
    logic                       r_frame_done;

    logic                       w_tick;
    logic                       w_wrap;
    logic                       w_blank;
    logic [6:0]                 w_seg_dec;
    logic [N_DIGITS-1:0]        w_an_sel;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    assign w_tick    = bus.habilita && (r_presc == PRESC_LAST);
    assign w_wrap    = w_tick && (r_idx == IDX_LAST);
    assign w_seg_dec = hex7(r_disp[r_idx]);
    assign w_an_sel  = ~(N_DIGITS'(1) << r_idx);

`ifdef DISPLAY_MUX_7SEG_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;

    // Phase flips after every BLINK_FRAMES completed frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_wrap) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    assign w_blank = r_blink_phase && bus.error_dig[r_idx];
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic w_unused_err;
    assign w_unused_err = ^bus.error_dig;
    assign w_blank      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_pend       <= '0;
            r_disp       <= '0;
            r_seg        <= 7'b1111111;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            if (bus.carga)
                r_pend <= bus.datos;
            // Display only updates on frame wrap; a coincident load bypasses the pending copy.
            if (w_wrap)
                r_disp <= bus.carga ? bus.datos : r_pend;
            if (bus.habilita)
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick)
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
            r_frame_done <= w_wrap;
            r_an         <= bus.habilita ? w_an_sel : '1;
            r_seg        <= (bus.habilita && !w_blank) ? w_seg_dec : 7'b1111111;
        end
    end

    assign bus.seg        = r_seg;
    assign bus.an         = r_an;
    assign bus.frame_done = r_frame_done;
endmodule
